// File: rtl/wb_slave_router.sv
// Wishbone slave router: decodes one master access onto NUM_IP+1 slave slots and returns a registered ack.
// Define WB_SLAVE_ROUTER_TIMEOUT_EN to build in the BUSY-state watchdog.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for cyc&stb; decodes the address
// BUSY    | strobing the latched slot, waiting for its ack
// RESP    | one-cycle ack to the master (slave data, miss or timeout data)
module wb_slave_router #(
    parameter int          NUM_IP      = 4,
    parameter logic [7:0]  IP_BASE     = 8'h30,
    parameter logic [7:0]  MEM_BASE    = 8'h38,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic [NUM_IP:0]             slv_valid,
    input  logic [NUM_IP:0]             slv_ack,
    input  logic [32*(NUM_IP+1)-1:0]    slv_dat,
    output logic                        bus_err,
    output logic [7:0]                  err_cnt,
    output logic                        timeout_flag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_rsp;

    logic        req;
    logic        dec_hit;
    logic [4:0]  dec_idx;
    logic        sel_ack;
    logic [31:0] sel_dat;

`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tcnt_q, tcnt_d;
    logic        tflag_q, tflag_d;
`endif

    // The remaining master fields fan out to the slaves outside this block.
    logic unused_master_fields;
    assign unused_master_fields = ^{wbs_we_i, wbs_sel_i, wbs_dat_i,
                                    wbs_adr_i[23:12], wbs_adr_i[7:0]};

    assign req = wbs_cyc_i & wbs_stb_i;

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        if (wbs_adr_i[31:24] == MEM_BASE) begin
            dec_hit = 1'b1;
        end else if (wbs_adr_i[31:24] == IP_BASE &&
                     {1'b0, wbs_adr_i[11:8]} < 5'(NUM_IP)) begin
            dec_hit = 1'b1;
            dec_idx = {1'b0, wbs_adr_i[11:8]} + 5'd1;
        end
    end

    always_comb begin
        sel_ack   = 1'b0;
        sel_dat   = '0;
        slv_valid = '0;
        for (int k = 0; k <= NUM_IP; k++) begin
            if (idx_q == 5'(k)) begin
                sel_ack      = slv_ack[k];
                sel_dat      = slv_dat[32*k +: 32];
                slv_valid[k] = (state_q == ST_BUSY);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        err_rsp   = 1'b0;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        tflag_d   = tflag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        state_d = ST_BUSY;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        dat_d   = '0;
                        err_rsp = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // A master abort takes precedence over a same-cycle slave ack or expiry.
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = 32'hFFFF_FFFF;
                    err_rsp = 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + 16'd1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (err_rsp) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
            tcnt_q    <= '0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            tflag_q   <= tflag_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign bus_err   = err_q;
    assign err_cnt   = err_cnt_q;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_router.sv
// Bench for wb_slave_router: directed vector table, randomized accesses against a
// transaction-level model, error-counter saturation and mid-transaction reset.
module tb_wb_slave_router;

    localparam int          NUM_IP = 4;
    localparam int          NS     = NUM_IP + 1;
    localparam int          TMO    = 8;
    localparam logic [7:0]  M_IP   = 8'h30;
    localparam logic [7:0]  M_MEM  = 8'h38;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cyc, stb, we;
    logic [3:0]             sel;
    logic [31:0]            adr, wdat;
    logic                   ack;
    logic [31:0]            rdat;
    logic [NS-1:0]          slv_valid;
    logic [NS-1:0]          slv_ack;
    logic [32*NS-1:0]       slv_dat;
    logic                   bus_err;
    logic [7:0]             err_cnt;
    logic                   timeout_flag;

    always #5 clk = ~clk;

    wb_slave_router #(.NUM_IP(NUM_IP), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .slv_valid(slv_valid), .slv_ack(slv_ack), .slv_dat(slv_dat),
        .bus_err(bus_err), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        int          delay;     // slave acks in BUSY cycle delay+1
        int          drop;      // master drops cyc/stb in this BUSY cycle (0 = never)
        int          spur;      // slot raising a spurious ack (-1 = none)
        logic [31:0] sdat;
        int          exp_slot;
        int          exp_busy;  // number of cycles slv_valid is expected high
        int          exp_ack;   // cycle of the ack after the request edge (0 = none)
        logic [31:0] exp_dat;
        logic        exp_err;
    } txn_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          m_err_cnt = 0;
    logic        m_flag = 1'b0;
    logic [31:0] m_last_dat = '0;
    txn_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input int d, input int dr,
                                input int sp, input logic [31:0] sd, input int slot, input int busy,
                                input int ak, input logic [31:0] ed, input logic ee);
        txn_t t;
        t.adr = a; t.we = w; t.delay = d; t.drop = dr; t.spur = sp; t.sdat = sd;
        t.exp_slot = slot; t.exp_busy = busy; t.exp_ack = ak; t.exp_dat = ed; t.exp_err = ee;
        return t;
    endfunction

    // Transaction-level reference: which slot, which event ends BUSY first, what comes back.
    function automatic txn_t predict(input txn_t t);
        txn_t r = t;
        logic [7:0] top = t.adr[31:24];
        int sub = int'(t.adr[11:8]);
        int a = t.delay + 1;
        int limit = 1 << 30;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
        limit = TMO;
`endif
        r.exp_slot = -1;
        if (top == M_MEM) r.exp_slot = 0;
        else if (top == M_IP && sub < NUM_IP) r.exp_slot = sub + 1;
        if (r.exp_slot < 0) begin
            r.exp_busy = 0; r.exp_ack = 1; r.exp_dat = 32'h0; r.exp_err = 1'b1;
        end else if (t.drop > 0 && t.drop < a && t.drop < limit) begin
            r.exp_busy = t.drop; r.exp_ack = 0; r.exp_dat = 32'h0; r.exp_err = 1'b0;
        end else if (a > limit) begin
            r.exp_busy = limit; r.exp_ack = limit + 1; r.exp_dat = 32'hFFFF_FFFF; r.exp_err = 1'b1;
        end else begin
            r.exp_busy = a; r.exp_ack = a + 1; r.exp_dat = t.sdat; r.exp_err = 1'b0;
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t);
        int          ack_first = 0;
        int          ack_n = 0;
        logic        v_bad = 1'b0, e_bad = 1'b0, h_bad = 1'b0;
        logic [31:0] ack_dat = '0;
        logic [31:0] hold_ref;
        logic [NS-1:0] exp_v;
        int          last;
        @(negedge clk);
        for (int k = 0; k < NS; k++)
            slv_dat[32*k +: 32] = (k == t.exp_slot) ? t.sdat : $urandom();
        adr = t.adr; we = t.we; sel = 4'hF; wdat = $urandom();
        cyc = 1'b1; stb = 1'b1; slv_ack = '0;
        last = ((t.exp_ack > t.exp_busy) ? t.exp_ack : t.exp_busy) + 3;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_v = '0;
            if (t.exp_slot >= 0 && c <= t.exp_busy) exp_v[t.exp_slot] = 1'b1;
            if (slv_valid !== exp_v) v_bad = 1'b1;
            if (bus_err !== (t.exp_err && c == t.exp_ack)) e_bad = 1'b1;
            hold_ref = (t.exp_ack != 0 && c > t.exp_ack) ? t.exp_dat : m_last_dat;
            if (ack === 1'b1) begin
                ack_n++;
                if (ack_first == 0) begin ack_first = c; ack_dat = rdat; end
                cyc = 1'b0; stb = 1'b0;
            end else if (rdat !== hold_ref) begin
                h_bad = 1'b1;
            end
            slv_ack = '0;
            if (t.exp_slot >= 0 && c == t.delay + 1) slv_ack[t.exp_slot] = 1'b1;
            if (t.spur >= 0 && c < t.delay + 1) slv_ack[t.spur] = 1'b1;
            if (t.drop > 0 && c >= t.drop) begin cyc = 1'b0; stb = 1'b0; end
        end
        cyc = 1'b0; stb = 1'b0; slv_ack = '0;
        if (t.exp_err) m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
        if (t.exp_err && t.exp_slot >= 0) m_flag = 1'b1;
        if (t.exp_ack != 0) m_last_dat = t.exp_dat;
        check("ack_cycle", ack_first, t.exp_ack);
        check("ack_count", ack_n, (t.exp_ack != 0) ? 1 : 0);
        if (t.exp_ack != 0) check("ack_data", ack_dat, t.exp_dat);
        check("valid_seq", {31'b0, v_bad}, 32'h0);
        check("bus_err_seq", {31'b0, e_bad}, 32'h0);
        check("dat_hold", {31'b0, h_bad}, 32'h0);
        check("err_cnt", {24'b0, err_cnt}, m_err_cnt);
        check("timeout_flag", {31'b0, timeout_flag}, {31'b0, m_flag});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   mx;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        slv_ack = '0; slv_dat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_valid", {27'b0, slv_valid}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        check("rst_timeout_flag", {31'b0, timeout_flag}, 32'h0);

        //                 adr           we  dly drop spur sdat          slot busy ack exp_dat       err
        tbl.push_back(mk(32'h3800_0010, 0,  2,  0,  -1, 32'h1234_5678,  0,   3,   4, 32'h1234_5678, 0));
        tbl.push_back(mk(32'h3000_0300, 1,  2,  0,   1, 32'hCAFE_F00D,  4,   3,   4, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(32'h3000_0500, 0,  0,  0,  -1, 32'h0,         -1,   0,   1, 32'h0,         1));
        tbl.push_back(mk(32'h2000_0000, 1,  0,  0,  -1, 32'h0,         -1,   0,   1, 32'h0,         1));
        tbl.push_back(mk(32'h3000_0000, 0,  0,  0,  -1, 32'hA5A5_0001,  1,   1,   2, 32'hA5A5_0001, 0));
        tbl.push_back(mk(32'h3000_0100, 0, 10,  2,  -1, 32'hDEAD_BEEF,  2,   2,   0, 32'h0,         0));
        tbl.push_back(mk(32'h38FF_FFFF, 1,  4,  0,   3, 32'h0BAD_F00D,  0,   5,   6, 32'h0BAD_F00D, 0));
        tbl.push_back(mk(32'h3000_0400, 0,  0,  0,  -1, 32'h0,         -1,   0,   1, 32'h0,         1));
        tbl.push_back(mk(32'h3000_0200, 0,  3,  0,   0, 32'h1357_9BDF,  3,   4,   5, 32'h1357_9BDF, 0));
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
        tbl.push_back(mk(32'h3000_0000, 0,  7,  0,  -1, 32'h2222_2222,  1,   8,   9, 32'h2222_2222, 0));
        tbl.push_back(mk(32'h3800_0000, 0, 30,  0,  -1, 32'h1111_1111,  0,   8,   9, 32'hFFFF_FFFF, 1));
`endif
        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            int s = int'($urandom_range(0, 3));
            t = mk($urandom(), 1'($urandom()), 0, 0, -1, $urandom(), 0, 0, 0, 0, 0);
            t.adr[31:24] = (s == 0) ? M_MEM : (s <= 2) ? M_IP : 8'($urandom_range(0, 255));
            t.adr[11:8]  = 4'($urandom_range(0, 7));
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
            t.delay = int'($urandom_range(0, 12));
            mx = (t.delay < TMO - 1) ? t.delay : TMO - 1;
`else
            t.delay = int'($urandom_range(0, 6));
            mx = t.delay;
`endif
            if (mx > 0 && $urandom_range(0, 4) == 0) t.drop = int'($urandom_range(1, mx));
            if ($urandom_range(0, 2) == 0) t.spur = int'($urandom_range(0, NUM_IP));
            t = predict(t);
            if (t.spur == t.exp_slot) t.spur = -1;
            run_txn(t);
        end

        for (int i = 0; i < 300; i++) begin
            t = mk({8'h20, 24'($urandom())}, 1'b0, 0, 0, -1, 32'h0, 0, 0, 0, 0, 0);
            run_txn(predict(t));
        end
        check("err_cnt_saturated", {24'b0, err_cnt}, 32'd255);

        // Reset in BUSY, with a same-cycle slave ack that must lose to reset.
        @(negedge clk);
        adr = 32'h3800_0000; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        check("pre_rst_valid", {27'b0, slv_valid}, 32'h1);
        rst = 1'b1; slv_ack = 5'b00001;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; slv_ack = '0;
        m_err_cnt = 0; m_flag = 1'b0; m_last_dat = '0;
        check("rst_busy_valid", {27'b0, slv_valid}, 32'h0);
        check("rst_busy_err_cnt", {24'b0, err_cnt}, 32'h0);
        check("rst_busy_dat", rdat, 32'h0);
        check("rst_busy_flag", {31'b0, timeout_flag}, 32'h0);
        mx = 0;
        for (int c = 0; c < 3; c++) begin
            if (ack === 1'b1) mx++;
            @(negedge clk);
        end
        check("rst_busy_no_ack", mx, 32'h0);
        run_txn(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
